segment_unit: RTL

Parametrised segment translation unit for the memory management unit's segmentation path. It holds SEG_COUNT segment registers (base, limit, valid), loads them in real mode (base = selector × 16) or protected mode (8-byte GDT descriptor fetched over a request/acknowledge bus), and translates segment:offset requests into linear addresses with limit checking. It sits between the execution unit's address generation and the paging unit, replacing the stateless real-mode base shifter.

---
 rtl/segment_pkg.sv | 37 +++
 rtl/segment_unit_if.sv | 39 +++
 rtl/segment_descriptor_decode.sv | 25 ++
 rtl/segment_unit.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/segment_pkg.sv
// Shared types and constants for the segment translation unit.
package segment_pkg;

    localparam int unsigned SEG_ES = 0;
    localparam int unsigned SEG_CS = 1;
    localparam int unsigned SEG_SS = 2;
    localparam int unsigned SEG_DS = 3;
    localparam int unsigned SEG_FS = 4;
    localparam int unsigned SEG_GS = 5;

    // Bit positions inside the high descriptor dword
    localparam int unsigned DESC_G_BIT = 23;
    localparam int unsigned DESC_P_BIT = 15;
    localparam int unsigned DESC_BASE_HI_MSB = 31;
    localparam int unsigned DESC_BASE_HI_LSB = 24;
    localparam int unsigned DESC_BASE_MID_MSB = 7;
    localparam int unsigned DESC_LIMIT_HI_MSB = 19;
    localparam int unsigned DESC_LIMIT_HI_LSB = 16;

    localparam logic [31:0] REAL_LIMIT = 32'h0000_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH_LO,
        ST_FETCH_HI,
        ST_COMMIT
    } load_state_e;

    typedef struct packed {
        logic [31:0] base;
        logic [31:0] limit;
        logic        valid;
    } seg_reg_t;

    localparam seg_reg_t SEG_RESET = '{base: 32'h0, limit: REAL_LIMIT, valid: 1'b1};

endpackage

// File: rtl/segment_unit_if.sv
// Load, descriptor-fetch and translation signals of the segment unit.
interface segment_unit_if #(
    parameter int unsigned SEG_IDX_W  = 3,
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  mode_protected;
    logic [31:0]           gdt_base;
    logic                  load_valid;
    logic                  load_ready;
    logic [SEG_IDX_W-1:0]  load_seg;
    logic [15:0]           load_selector;
    logic                  load_done;
    logic                  load_fault;
    logic                  desc_req;
    logic [31:0]           desc_addr;
    logic                  desc_ack;
    logic [31:0]           desc_data;
    logic                  xlat_valid;
    logic [SEG_IDX_W-1:0]  xlat_seg;
    logic [31:0]           xlat_offset;
    logic [1:0]            xlat_size;
    logic                  out_valid;
    logic [ADDR_WIDTH-1:0] out_linear;
    logic                  out_fault;

    modport master (
        output mode_protected, gdt_base, load_valid, load_seg, load_selector,
               desc_ack, desc_data, xlat_valid, xlat_seg, xlat_offset, xlat_size,
        input  load_ready, load_done, load_fault, desc_req, desc_addr,
               out_valid, out_linear, out_fault
    );

    modport slave (
        input  mode_protected, gdt_base, load_valid, load_seg, load_selector,
               desc_ack, desc_data, xlat_valid, xlat_seg, xlat_offset, xlat_size,
        output load_ready, load_done, load_fault, desc_req, desc_addr,
               out_valid, out_linear, out_fault
    );
endinterface

// File: rtl/segment_descriptor_decode.sv
// Combinational decode of an 8-byte GDT descriptor into base, limit and present.
module segment_descriptor_decode
    import segment_pkg::*;
(
    input  logic [31:0] i_lo,
    input  logic [31:0] i_hi,
    output logic [31:0] o_base_c,
    output logic [31:0] o_limit_c,
    output logic        o_present_c
);
    logic [19:0] w_limit20;
    logic        w_unused_bits;

    always_comb begin
        o_base_c    = {i_hi[DESC_BASE_HI_MSB:DESC_BASE_HI_LSB], i_hi[DESC_BASE_MID_MSB:0], i_lo[31:16]};
        w_limit20   = {i_hi[DESC_LIMIT_HI_MSB:DESC_LIMIT_HI_LSB], i_lo[15:0]};
        // Granularity scales the 20-bit limit to 4 KiB pages
        o_limit_c   = i_hi[DESC_G_BIT] ? {w_limit20, 12'hFFF} : {12'h000, w_limit20};
        o_present_c = i_hi[DESC_P_BIT];
    end

    // Type/DPL/AVL/D-B fields are not used by this unit
    assign w_unused_bits = ^{i_hi[22:20], i_hi[14:8]};

endmodule

// File: rtl/segment_unit.sv
// Segment register file with real/protected-mode loader and 1-cycle pipelined translation.
module segment_unit
    import segment_pkg::*;
#(
    parameter int unsigned SEG_COUNT  = 6,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned SEG_IDX_W  = $clog2(SEG_COUNT)
) (
    input  logic         clk,
    input  logic         reset_n,
    segment_unit_if.slave bus
);
    load_state_e           r_state;
    load_state_e           w_next_state;

    seg_reg_t              r_segs [SEG_COUNT];

    logic [SEG_IDX_W-1:0]  r_seg;
    logic [15:0]           r_selector;
    logic                  r_prot;
    logic                  r_null;
    logic [31:0]           r_lo;
    logic [31:0]           r_hi;
    logic [31:0]           r_desc_addr;
    logic                  r_desc_req;
    logic                  r_load_ready;
    logic                  r_load_done;
    logic                  r_load_fault;

    logic                  r_out_valid;
    logic [ADDR_WIDTH-1:0] r_out_linear;
    logic                  r_out_fault;

    logic                  w_accept;
    logic                  w_commit_we;
    logic                  w_commit_inval;
    logic                  w_commit_fault;
    seg_reg_t              w_commit_val;
    logic [31:0]           w_dec_base;
    logic [31:0]           w_dec_limit;
    logic                  w_dec_present;

    logic                  w_xseg_ok;
    seg_reg_t              w_xent;
    logic [32:0]           w_xend;
    logic [31:0]           w_xlin;
    logic                  w_xfault;

    segment_descriptor_decode u_decode (
        .i_lo        (r_lo),
        .i_hi        (r_hi),
        .o_base_c    (w_dec_base),
        .o_limit_c   (w_dec_limit),
        .o_present_c (w_dec_present)
    );

    assign w_accept = (r_state == ST_IDLE) && bus.load_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_next_state;
    end

    // Next state plus the commit decision taken in COMMIT
    always_comb begin
        w_next_state   = r_state;
        w_commit_we    = 1'b0;
        w_commit_inval = 1'b0;
        w_commit_fault = 1'b0;
        w_commit_val   = SEG_RESET;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.load_valid) begin
                    if (bus.mode_protected && (bus.load_selector[15:3] != 13'h0))
                        w_next_state = ST_FETCH_LO;
                    else
                        w_next_state = ST_COMMIT;
                end
            end
            ST_FETCH_LO: if (bus.desc_ack) w_next_state = ST_FETCH_HI;
            ST_FETCH_HI: if (bus.desc_ack) w_next_state = ST_COMMIT;
            ST_COMMIT: begin
                w_next_state = ST_IDLE;
                if (32'(r_seg) >= SEG_COUNT) begin
                    w_commit_fault = 1'b1;
                end else if (!r_prot) begin
                    w_commit_we  = 1'b1;
                    w_commit_val = '{base: {12'h000, r_selector, 4'h0}, limit: REAL_LIMIT, valid: 1'b1};
                end else if (r_null) begin
                    w_commit_we    = 1'b1;
                    w_commit_inval = 1'b1;
                end else if (!w_dec_present) begin
                    w_commit_fault = 1'b1;
                end else begin
                    w_commit_we  = 1'b1;
                    w_commit_val = '{base: w_dec_base, limit: w_dec_limit, valid: 1'b1};
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Load capture, descriptor bus and handshake outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_seg        <= '0;
            r_selector   <= 16'h0;
            r_prot       <= 1'b0;
            r_null       <= 1'b0;
            r_lo         <= 32'h0;
            r_hi         <= 32'h0;
            r_desc_addr  <= 32'h0;
            r_desc_req   <= 1'b0;
            r_load_ready <= 1'b1;
            r_load_done  <= 1'b0;
            r_load_fault <= 1'b0;
        end else begin
            r_load_ready <= (w_next_state == ST_IDLE);
            r_load_done  <= (r_state == ST_COMMIT);
            r_load_fault <= w_commit_fault;
            r_desc_req   <= (w_next_state == ST_FETCH_LO) || (w_next_state == ST_FETCH_HI);
            if (w_accept) begin
                r_seg      <= bus.load_seg;
                r_selector <= bus.load_selector;
                r_prot     <= bus.mode_protected;
                r_null     <= (bus.load_selector[15:3] == 13'h0);
                if (w_next_state == ST_FETCH_LO)
                    r_desc_addr <= bus.gdt_base + 32'({bus.load_selector[15:3], 3'b000});
            end
            if ((r_state == ST_FETCH_LO) && bus.desc_ack) begin
                r_lo        <= bus.desc_data;
                r_desc_addr <= r_desc_addr + 32'd4;
            end
            if ((r_state == ST_FETCH_HI) && bus.desc_ack)
                r_hi <= bus.desc_data;
        end
    end

    // Segment register file; a null load only clears the valid bit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < SEG_COUNT; i++) r_segs[i] <= SEG_RESET;
        end else if (w_commit_we) begin
            for (int unsigned i = 0; i < SEG_COUNT; i++) begin
                if (r_seg == SEG_IDX_W'(i)) begin
                    if (w_commit_inval) r_segs[i].valid <= 1'b0;
                    else                r_segs[i]       <= w_commit_val;
                end
            end
        end
    end

    always_comb begin
        w_xseg_ok = (32'(bus.xlat_seg) < SEG_COUNT);
        w_xent    = w_xseg_ok ? r_segs[bus.xlat_seg] : '0;
        w_xend    = {1'b0, bus.xlat_offset} + 33'(bus.xlat_size);
        w_xlin    = w_xent.base + bus.xlat_offset;
        w_xfault  = !w_xseg_ok || (w_xend > {1'b0, w_xent.limit}) ||
                    (bus.mode_protected && !w_xent.valid);
    end

    // Translation pipeline stage; reads pre-commit register values
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid  <= 1'b0;
            r_out_linear <= '0;
            r_out_fault  <= 1'b0;
        end else begin
            r_out_valid <= bus.xlat_valid;
            r_out_fault <= bus.xlat_valid && w_xfault;
            if (bus.xlat_valid) r_out_linear <= ADDR_WIDTH'(w_xlin);
        end
    end

    assign bus.load_ready = r_load_ready;
    assign bus.load_done  = r_load_done;
    assign bus.load_fault = r_load_fault;
    assign bus.desc_req   = r_desc_req;
    assign bus.desc_addr  = r_desc_addr;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_linear = r_out_linear;
    assign bus.out_fault  = r_out_fault;

endmodule
